// File: rtl/gpu_pkg.sv
// gpu_pkg: shared owner ids, DMA window state encoding and default base addresses
package gpu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MAP1, S_GFX1, S_MAP2, S_GFX2, S_OBJ, S_REF, S_DONE} state_t;
  localparam logic [2:0] ID_MAP1 = 3'd0;
  localparam logic [2:0] ID_GFX1 = 3'd1;
  localparam logic [2:0] ID_MAP2 = 3'd2;
  localparam logic [2:0] ID_GFX2 = 3'd3;
  localparam logic [2:0] ID_OBJ  = 3'd4;
  localparam logic [2:0] ID_NONE = 3'd7;
  localparam logic [21:0] BASE_MAP1_DEF = 22'h00000;
  localparam logic [21:0] BASE_GFX1_DEF = 22'h10000;
  localparam logic [21:0] BASE_MAP2_DEF = 22'h04000;
  localparam logic [21:0] BASE_GFX2_DEF = 22'h50000;
  localparam logic [21:0] BASE_OBJ_DEF  = 22'h90000;
  function automatic logic [2:0] owner_id(state_t s);
    return s == S_MAP1 ? ID_MAP1 : s == S_GFX1 ? ID_GFX1 : s == S_MAP2 ? ID_MAP2 :
           s == S_GFX2 ? ID_GFX2 : s == S_OBJ ? ID_OBJ : ID_NONE;
  endfunction
endpackage

// File: rtl/gpu_dma_route.sv
// gpu_dma_route: owner-id delay line that steers returned read data valid to the issuing client
module gpu_dma_route
  import gpu_pkg::*;
#(
  parameter int RD_LAT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [2:0] id,
  input  logic       ram_data_vld,
  output logic       map1_vld,
  output logic       gfx1_vld,
  output logic       map2_vld,
  output logic       gfx2_vld,
  output logic       obj_vld
);
  // d[0] is captured together with dma_rden; d[RD_LAT] lines up with ram_data_vld
  logic [2:0] d [RD_LAT+1];
  logic [2:0] tap;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) d[i] <= ID_NONE;
    end else begin
      d[0] <= ld ? id : ID_NONE;
      for (int i = 1; i <= RD_LAT; i++) d[i] <= d[i-1];
    end
  always_comb begin
    tap = d[RD_LAT];
    map1_vld = ram_data_vld & (tap == ID_MAP1);
    gfx1_vld = ram_data_vld & (tap == ID_GFX1);
    map2_vld = ram_data_vld & (tap == ID_MAP2);
    gfx2_vld = ram_data_vld & (tap == ID_GFX2);
    obj_vld  = ram_data_vld & (tap == ID_OBJ);
  end
endmodule

// File: rtl/gpu_dma_sched.sv
// gpu_dma_sched: per-line SDRAM slot windowing, client address mux and read-return routing
module gpu_dma_sched
  import gpu_pkg::*;
#(
  parameter int          W_MAP1    = 8,
  parameter int          W_GFX1    = 16,
  parameter int          W_MAP2    = 8,
  parameter int          W_GFX2    = 16,
  parameter int          W_OBJ     = 64,
  parameter int          W_REF     = 2,
  parameter int          RD_LAT    = 6,
  parameter logic [21:0] BASE_MAP1 = BASE_MAP1_DEF,
  parameter logic [21:0] BASE_GFX1 = BASE_GFX1_DEF,
  parameter logic [21:0] BASE_MAP2 = BASE_MAP2_DEF,
  parameter logic [21:0] BASE_GFX2 = BASE_GFX2_DEF,
  parameter logic [21:0] BASE_OBJ  = BASE_OBJ_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_dma_ena,
  input  logic        bus_eol,
  input  logic [3:0]  ram_cyc,
  input  logic [3:0]  ram_ph,
  output logic        map1_ena,
  output logic        gfx1_ena,
  output logic        map2_ena,
  output logic        gfx2_ena,
  output logic        obj_ena,
  input  logic [13:0] map1_addr,
  input  logic        map1_rden,
  input  logic [15:0] gfx1_addr,
  input  logic        gfx1_rden,
  input  logic [13:0] map2_addr,
  input  logic        map2_rden,
  input  logic [15:0] gfx2_addr,
  input  logic        gfx2_rden,
  input  logic [15:0] obj_addr,
  input  logic        obj_rden,
  output logic [21:0] dma_addr,
  output logic        dma_rden,
  output logic        ref_req,
  input  logic        ram_data_vld,
  output logic        map1_vld,
  output logic        gfx1_vld,
  output logic        map2_vld,
  output logic        gfx2_vld,
  output logic        obj_vld,
  output logic        line_ovr
);
  function automatic logic [8:0] wlen(state_t s);
    return s == S_MAP1 ? 9'(W_MAP1) : s == S_GFX1 ? 9'(W_GFX1) : s == S_MAP2 ? 9'(W_MAP2) :
           s == S_GFX2 ? 9'(W_GFX2) : s == S_OBJ ? 9'(W_OBJ) : s == S_REF ? 9'(W_REF) : 9'd0;
  endfunction
  // advance past zero-length windows; DONE terminates the chain
  function automatic state_t skip(state_t s);
    state_t t = s;
    for (int i = 0; i < 6; i++) t = (t != S_DONE && wlen(t) == 9'd0) ? state_t'(t + 3'd1) : t;
    return t;
  endfunction
  state_t      st, ns;
  logic [8:0]  sc, nsc;
  logic [2:0]  own;
  logic [21:0] base, ofs;
  logic        rd, slot, samp, last, unused_ph;
  assign unused_ph = ^{ram_cyc[3:2], ram_ph[3], ram_ph[1]};
  always_comb begin
    slot = ram_cyc[0] & ram_ph[0];
    samp = ram_cyc[1] & ram_ph[2];
    last = sc == wlen(st) - 9'd1;
    ns = st;
    nsc = sc;
    if (!bus_dma_ena) begin
      ns = S_IDLE;
      nsc = '0;
    end else if (bus_eol) begin
      ns = skip(S_MAP1);
      nsc = '0;
    end else if (slot && st != S_IDLE && st != S_DONE) begin
      ns = last ? skip(state_t'(st + 3'd1)) : st;
      nsc = last ? '0 : sc + 9'd1;
    end
  end
  always_comb begin
    own = owner_id(st);
    base = own == ID_MAP1 ? BASE_MAP1 : own == ID_GFX1 ? BASE_GFX1 : own == ID_MAP2 ? BASE_MAP2 :
           own == ID_GFX2 ? BASE_GFX2 : own == ID_OBJ ? BASE_OBJ : '0;
    ofs = own == ID_MAP1 ? {8'd0, map1_addr} : own == ID_GFX1 ? {4'd0, gfx1_addr, 2'b00} :
          own == ID_MAP2 ? {8'd0, map2_addr} : own == ID_GFX2 ? {4'd0, gfx2_addr, 2'b00} :
          own == ID_OBJ ? {4'd0, obj_addr, 2'b00} : '0;
    rd = own == ID_MAP1 ? map1_rden : own == ID_GFX1 ? gfx1_rden : own == ID_MAP2 ? map2_rden :
         own == ID_GFX2 ? gfx2_rden : own == ID_OBJ ? obj_rden : 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= S_IDLE;
      sc <= '0;
      {obj_ena, gfx2_ena, map2_ena, gfx1_ena, map1_ena} <= '0;
      ref_req <= 1'b0;
      line_ovr <= 1'b0;
      dma_addr <= '0;
      dma_rden <= 1'b0;
    end else begin
      st <= ns;
      sc <= nsc;
      {obj_ena, gfx2_ena, map2_ena, gfx1_ena, map1_ena} <=
        {ns == S_OBJ, ns == S_GFX2, ns == S_MAP2, ns == S_GFX1, ns == S_MAP1};
      ref_req <= ns == S_REF;
      line_ovr <= bus_dma_ena & bus_eol & st != S_IDLE & st != S_DONE;
      if (samp) begin
        dma_addr <= base + ofs;
        dma_rden <= rd & bus_dma_ena;
      end
    end
  gpu_dma_route #(.RD_LAT(RD_LAT)) u_route (
    .clk(clk),
    .rst(rst),
    .ld(samp & rd & bus_dma_ena),
    .id(own),
    .ram_data_vld(ram_data_vld),
    .map1_vld(map1_vld),
    .gfx1_vld(gfx1_vld),
    .map2_vld(map2_vld),
    .gfx2_vld(gfx2_vld),
    .obj_vld(obj_vld)
  );
endmodule
